// File: rtl/arq_seqn_ctrl.sv
// Per-LT_ADDR baseband ARQ/SEQN engine: tracks SEQN/ARQN, duplicate detection and unacked TX data.
// Optional statistics counters are built only when ARQ_STATS_EN is defined.
module arq_seqn_ctrl #(
  parameter int NLT   = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_clk_6M,
  input  logic             i_rst,
  input  logic             i_conns,
  input  logic             i_rx_done_p,
  input  logic             i_dec_hecgood,
  input  logic             i_lt_addressed,
  input  logic [2:0]       i_dec_lt_addr,
  input  logic [3:0]       i_dec_pk_type,
  input  logic [NLT-1:0]   i_dec_arqn,
  input  logic             i_dec_seqn,
  input  logic             i_rx_crcgood,
  input  logic             i_tx_done_p,
  input  logic [2:0]       i_tx_lt_addr,
  input  logic [3:0]       i_txpktype,
  input  logic             i_flush_p,
  input  logic [2:0]       i_flush_lt_addr,
  output logic [NLT-1:0]   o_txaclSEQN,
  output logic [NLT-1:0]   o_txARQN,
  output logic [NLT-1:0]   o_tx_retx,
  output logic             o_rx_accept_p,
  output logic             o_rx_dup_p,
  output logic             o_tx_ack_p,
  output logic [CNT_W-1:0] o_retx_cnt,
  output logic [CNT_W-1:0] o_dup_cnt,
  output logic [CNT_W-1:0] o_crcerr_cnt
);

  logic [NLT-1:0] r_seqn, r_arqn, r_outst, r_lastrx_seqn, r_lastrx_vld;
  logic [NLT-1:0] w_seqn_n, w_arqn_n, w_outst_n, w_lastrx_seqn_n, w_lastrx_vld_n;
  logic           r_rx_accept_p, r_rx_dup_p, r_tx_ack_p;
  logic           w_acc, w_dup, w_ack;
  logic           w_rx_ev, w_rx_live, w_rx_data, w_rx_bcast, w_dup_hit, w_tx_data;

  // NULL, POLL and FHS carry no ARQ-protected payload
  function automatic logic is_data(input logic [3:0] t);
    return (t != 4'b0000) && (t != 4'b0001) && (t != 4'b0010);
  endfunction

  assign w_rx_ev    = i_rx_done_p & i_conns & i_dec_hecgood & i_lt_addressed;
  // A flush on the same LT overrides the whole RX evaluation, including pulses and counters
  assign w_rx_live  = w_rx_ev & ~(i_flush_p & (i_flush_lt_addr == i_dec_lt_addr));
  assign w_rx_data  = is_data(i_dec_pk_type);
  assign w_rx_bcast = (i_dec_lt_addr == 3'd0);
  assign w_dup_hit  = r_lastrx_vld[i_dec_lt_addr] & (i_dec_seqn == r_lastrx_seqn[i_dec_lt_addr]);
  assign w_tx_data  = is_data(i_txpktype) & (i_tx_lt_addr != 3'd0);

  always_comb begin
    w_seqn_n        = r_seqn;
    w_arqn_n        = r_arqn;
    w_outst_n       = r_outst;
    w_lastrx_seqn_n = r_lastrx_seqn;
    w_lastrx_vld_n  = r_lastrx_vld;
    w_acc           = 1'b0;
    w_dup           = 1'b0;
    w_ack           = 1'b0;
    if (w_rx_live) begin
      if (r_outst[i_dec_lt_addr] && i_dec_arqn[i_dec_lt_addr]) begin
        w_seqn_n[i_dec_lt_addr]  = ~r_seqn[i_dec_lt_addr];
        w_outst_n[i_dec_lt_addr] = 1'b0;
        w_ack                    = 1'b1;
      end
      if (w_rx_data) begin
        if (w_rx_bcast) begin
          w_acc = i_rx_crcgood;
        end else if (w_dup_hit) begin
          w_arqn_n[i_dec_lt_addr] = 1'b1;
          w_dup                   = 1'b1;
        end else if (i_rx_crcgood) begin
          w_arqn_n[i_dec_lt_addr]        = 1'b1;
          w_lastrx_seqn_n[i_dec_lt_addr] = i_dec_seqn;
          w_lastrx_vld_n[i_dec_lt_addr]  = 1'b1;
          w_acc                          = 1'b1;
        end else begin
          w_arqn_n[i_dec_lt_addr] = 1'b0;
        end
      end
    end
    // Applied after the ACK so a same-cycle ACK and new send leaves data outstanding
    if (i_tx_done_p && i_conns && w_tx_data) begin
      w_outst_n[i_tx_lt_addr] = 1'b1;
    end
    if (i_flush_p) begin
      w_seqn_n[i_flush_lt_addr]       = 1'b1;
      w_arqn_n[i_flush_lt_addr]       = 1'b0;
      w_outst_n[i_flush_lt_addr]      = 1'b0;
      w_lastrx_vld_n[i_flush_lt_addr] = 1'b0;
    end
  end

  always_ff @(posedge i_clk_6M) begin
    if (i_rst || !i_conns) begin
      r_seqn        <= '1;
      r_arqn        <= '0;
      r_outst       <= '0;
      r_lastrx_seqn <= '0;
      r_lastrx_vld  <= '0;
      r_rx_accept_p <= 1'b0;
      r_rx_dup_p    <= 1'b0;
      r_tx_ack_p    <= 1'b0;
    end else begin
      r_seqn        <= w_seqn_n;
      r_arqn        <= w_arqn_n;
      r_outst       <= w_outst_n;
      r_lastrx_seqn <= w_lastrx_seqn_n;
      r_lastrx_vld  <= w_lastrx_vld_n;
      r_rx_accept_p <= w_acc;
      r_rx_dup_p    <= w_dup;
      r_tx_ack_p    <= w_ack;
    end
  end

  assign o_txaclSEQN   = r_seqn;
  assign o_txARQN      = r_arqn;
  assign o_tx_retx     = r_outst;
  assign o_rx_accept_p = r_rx_accept_p;
  assign o_rx_dup_p    = r_rx_dup_p;
  assign o_tx_ack_p    = r_tx_ack_p;

`ifdef ARQ_STATS_EN
  logic [CNT_W-1:0] r_retx_cnt, r_dup_cnt, r_crcerr_cnt;
  logic             w_retx_ev, w_crcerr_ev;

  assign w_retx_ev   = w_rx_live & r_outst[i_dec_lt_addr] & ~i_dec_arqn[i_dec_lt_addr];
  assign w_crcerr_ev = w_rx_live & w_rx_data & ~w_rx_bcast & ~w_dup_hit & ~i_rx_crcgood;

  // Counters survive a connection drop; only reset clears them, and they saturate
  always_ff @(posedge i_clk_6M) begin
    if (i_rst) begin
      r_retx_cnt   <= '0;
      r_dup_cnt    <= '0;
      r_crcerr_cnt <= '0;
    end else begin
      if (w_retx_ev && (r_retx_cnt != '1))     r_retx_cnt   <= r_retx_cnt + CNT_W'(1);
      if (w_dup && (r_dup_cnt != '1))          r_dup_cnt    <= r_dup_cnt + CNT_W'(1);
      if (w_crcerr_ev && (r_crcerr_cnt != '1)) r_crcerr_cnt <= r_crcerr_cnt + CNT_W'(1);
    end
  end

  assign o_retx_cnt   = r_retx_cnt;
  assign o_dup_cnt    = r_dup_cnt;
  assign o_crcerr_cnt = r_crcerr_cnt;
`else
  assign o_retx_cnt   = '0;
  assign o_dup_cnt    = '0;
  assign o_crcerr_cnt = '0;
`endif

endmodule

// File: tb/tb_arq_seqn_ctrl.sv
// Directed bench for arq_seqn_ctrl; counter expectations follow whether ARQ_STATS_EN is defined.
module tb_arq_seqn_ctrl;

`ifdef ARQ_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  localparam logic [3:0] T_NULL = 4'b0000;
  localparam logic [3:0] T_POLL = 4'b0001;
  localparam logic [3:0] T_DM1  = 4'b0011;
  localparam logic [3:0] T_DH1  = 4'b0100;

  logic        clk = 1'b0;
  logic        rst, conns;
  logic        rx_done_p, dec_hecgood, lt_addressed, dec_seqn, rx_crcgood;
  logic [2:0]  dec_lt_addr, tx_lt_addr, flush_lt_addr;
  logic [3:0]  dec_pk_type, txpktype;
  logic [7:0]  dec_arqn;
  logic        tx_done_p, flush_p;
  logic [7:0]  txaclSEQN, txARQN, tx_retx;
  logic        rx_accept_p, rx_dup_p, tx_ack_p;
  logic [15:0] retx_cnt, dup_cnt, crcerr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  arq_seqn_ctrl dut (
    .i_clk_6M(clk), .i_rst(rst), .i_conns(conns),
    .i_rx_done_p(rx_done_p), .i_dec_hecgood(dec_hecgood), .i_lt_addressed(lt_addressed),
    .i_dec_lt_addr(dec_lt_addr), .i_dec_pk_type(dec_pk_type), .i_dec_arqn(dec_arqn),
    .i_dec_seqn(dec_seqn), .i_rx_crcgood(rx_crcgood),
    .i_tx_done_p(tx_done_p), .i_tx_lt_addr(tx_lt_addr), .i_txpktype(txpktype),
    .i_flush_p(flush_p), .i_flush_lt_addr(flush_lt_addr),
    .o_txaclSEQN(txaclSEQN), .o_txARQN(txARQN), .o_tx_retx(tx_retx),
    .o_rx_accept_p(rx_accept_p), .o_rx_dup_p(rx_dup_p), .o_tx_ack_p(tx_ack_p),
    .o_retx_cnt(retx_cnt), .o_dup_cnt(dup_cnt), .o_crcerr_cnt(crcerr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; registered results are read at the same offset
  task automatic step();
    @(posedge clk);
    #1;
    rx_done_p = 1'b0;
    tx_done_p = 1'b0;
    flush_p   = 1'b0;
  endtask

  task automatic set_rx(input logic [2:0] lt, input logic [3:0] t, input logic [7:0] arqn,
                        input logic sq, input logic crc, input logic hec);
    rx_done_p    = 1'b1;
    dec_hecgood  = hec;
    lt_addressed = hec;
    dec_lt_addr  = lt;
    dec_pk_type  = t;
    dec_arqn     = arqn;
    dec_seqn     = sq;
    rx_crcgood   = crc;
  endtask

  task automatic set_tx(input logic [2:0] lt, input logic [3:0] t);
    tx_done_p  = 1'b1;
    tx_lt_addr = lt;
    txpktype   = t;
  endtask

  task automatic chk_pulses(input string tag, input logic acc, input logic dup, input logic ack);
    chk({tag, "_accept"}, {31'd0, rx_accept_p}, {31'd0, acc});
    chk({tag, "_dup"},    {31'd0, rx_dup_p},    {31'd0, dup});
    chk({tag, "_ack"},    {31'd0, tx_ack_p},    {31'd0, ack});
  endtask

  initial begin
    rst = 1'b1; conns = 1'b1;
    rx_done_p = 1'b0; dec_hecgood = 1'b0; lt_addressed = 1'b0; dec_lt_addr = 3'd0;
    dec_pk_type = T_NULL; dec_arqn = 8'h00; dec_seqn = 1'b0; rx_crcgood = 1'b0;
    tx_done_p = 1'b0; tx_lt_addr = 3'd0; txpktype = T_NULL; flush_p = 1'b0; flush_lt_addr = 3'd0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_seqn", {24'd0, txaclSEQN}, 32'hFF);
    chk("rst_arqn", {24'd0, txARQN}, 32'h00);
    chk("rst_retx", {24'd0, tx_retx}, 32'h00);
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_retx_cnt", {16'd0, retx_cnt}, 32'd0);

    // Send DM1 on LT1, then ACK via POLL
    set_tx(3'd1, T_DM1); step();
    chk("tx1_retx", {24'd0, tx_retx}, 32'h02);
    set_rx(3'd1, T_POLL, 8'h02, 1'b0, 1'b0, 1'b1); step();
    chk_pulses("ack1", 1'b0, 1'b0, 1'b1);
    chk("ack1_seqn", {24'd0, txaclSEQN}, 32'hFD);
    chk("ack1_retx", {24'd0, tx_retx}, 32'h00);
    step();
    chk("ack1_pulse_width", {31'd0, tx_ack_p}, 32'd0);

    // New payload then duplicate on LT2
    set_rx(3'd2, T_DM1, 8'h00, 1'b1, 1'b1, 1'b1); step();
    chk_pulses("acc2", 1'b1, 1'b0, 1'b0);
    chk("acc2_arqn", {24'd0, txARQN}, 32'h04);
    set_rx(3'd2, T_DM1, 8'h00, 1'b1, 1'b1, 1'b1); step();
    chk_pulses("dup2", 1'b0, 1'b1, 1'b0);
    chk("dup2_arqn", {24'd0, txARQN}, 32'h04);
    chk("dup2_cnt", {16'd0, dup_cnt}, STATS);

    // CRC failure on DH1 seqn=0 NAKs; last accepted SEQN remains 1
    set_rx(3'd2, T_DH1, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk_pulses("crc2", 1'b0, 1'b0, 1'b0);
    chk("crc2_arqn", {24'd0, txARQN}, 32'h00);
    chk("crc2_cnt", {16'd0, crcerr_cnt}, STATS);
    set_rx(3'd2, T_DM1, 8'h00, 1'b1, 1'b0, 1'b1); step();
    chk_pulses("dup2b", 1'b0, 1'b1, 1'b0);
    chk("dup2b_arqn", {24'd0, txARQN}, 32'h04);
    chk("dup2b_cnt", {16'd0, dup_cnt}, 2 * STATS);

    // Outstanding on LT3, three NAKs
    set_tx(3'd3, T_DM1); step();
    for (int i = 0; i < 3; i++) begin
      set_rx(3'd3, T_POLL, 8'h00, 1'b0, 1'b0, 1'b1); step();
      chk_pulses("nak3", 1'b0, 1'b0, 1'b0);
    end
    chk("nak3_retx", {24'd0, tx_retx}, 32'h08);
    chk("nak3_cnt", {16'd0, retx_cnt}, 3 * STATS);
    chk("nak3_seqn", {24'd0, txaclSEQN}, 32'hFD);
    chk("nak3_arqn", {24'd0, txARQN}, 32'h04);

    // Flush LT3 concurrently with its ACK
    set_rx(3'd3, T_POLL, 8'h08, 1'b0, 1'b0, 1'b1);
    flush_p = 1'b1; flush_lt_addr = 3'd3;
    step();
    chk_pulses("flush3", 1'b0, 1'b0, 1'b0);
    chk("flush3_seqn", {24'd0, txaclSEQN}, 32'hFD);
    chk("flush3_retx", {24'd0, tx_retx}, 32'h00);

    // Bad HEC is ignored entirely
    set_rx(3'd5, T_DM1, 8'h00, 1'b0, 1'b1, 1'b0); step();
    chk_pulses("hec5", 1'b0, 1'b0, 1'b0);
    chk("hec5_arqn", {24'd0, txARQN}, 32'h04);

    // Broadcast payload accepted without touching ARQN
    set_rx(3'd0, T_DM1, 8'h00, 1'b1, 1'b1, 1'b1); step();
    chk_pulses("bc0", 1'b1, 1'b0, 1'b0);
    chk("bc0_arqn", {24'd0, txARQN}, 32'h04);
    chk("bc0_seqn", {24'd0, txaclSEQN}, 32'hFD);

    // Same-cycle ACK and new TX on LT1: SEQN toggles back, data stays outstanding
    set_tx(3'd1, T_DM1); step();
    set_rx(3'd1, T_POLL, 8'h02, 1'b0, 1'b0, 1'b1);
    set_tx(3'd1, T_DM1);
    step();
    chk_pulses("ackt1", 1'b0, 1'b0, 1'b1);
    chk("ackt1_seqn", {24'd0, txaclSEQN}, 32'hFF);
    chk("ackt1_retx", {24'd0, tx_retx}, 32'h02);

    // Connection drop resets link state but keeps counters
    conns = 1'b0; step();
    conns = 1'b1;
    chk("conn_arqn", {24'd0, txARQN}, 32'h00);
    chk("conn_retx", {24'd0, tx_retx}, 32'h00);
    chk("conn_seqn", {24'd0, txaclSEQN}, 32'hFF);
    chk("conn_cnt", {16'd0, retx_cnt}, 3 * STATS);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
